// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the FP MAC operand path: reader FSM states,
// default operand/SRAM geometry and the active-low SRAM control levels.
package fp_mac_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 4;
  // Width of the presented pair index (covers DEPTH entries).
  localparam int unsigned IDX_W  = 3;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StWait,
    StOffer,
    StDone
  } rd_state_e;

endpackage

// File: rtl/sram_pair_reader_if.sv
// Bus between the pair reader, the two operand SRAMs, the run controller and
// the downstream FP MAC consumer. master = reader side, slave = environment side.
interface sram_pair_reader_if #(
  parameter int unsigned DATA_W = fp_mac_pkg::DATA_W,
  parameter int unsigned ADDR_W = fp_mac_pkg::ADDR_W
);

  logic              start;
  logic              abort;
  logic              cs_a_n;
  logic              cs_b_n;
  logic              oe_a_n;
  logic              oe_b_n;
  logic              we_a_n;
  logic              we_b_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_a_in;
  logic [DATA_W-1:0] data_b_in;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_idx;
  logic              pair_valid;
  logic              pair_ready;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, data_a_in, data_b_in, pair_ready,
    output cs_a_n, cs_b_n, oe_a_n, oe_b_n, we_a_n, we_b_n, addr,
           op_a, op_b, op_idx, pair_valid, last, busy, done
  );

  modport slave (
    output start, abort, data_a_in, data_b_in, pair_ready,
    input  cs_a_n, cs_b_n, oe_a_n, oe_b_n, we_a_n, we_b_n, addr,
           op_a, op_b, op_idx, pair_valid, last, busy, done
  );

endinterface

// File: rtl/sram_rd_timer.sv
// Down-counter that stretches an SRAM read access by WAIT_CYCLES cycles.
// load presets the count; expire is high during the final wait cycle.
module sram_rd_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Preset on load, otherwise count down once per wait cycle, saturating at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(WAIT_CYCLES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CntW'(1));

endmodule

// File: rtl/sram_pair_reader.sv
// Read-side sequencer for operand SRAMs A and B. After start it reads entries
// 0..DEPTH-1 of both SRAMs in lockstep and offers each captured pair to the
// FP MAC over pair_valid/pair_ready. Never writes the SRAMs.
// Optional: define SRAM_RD_WAIT_EN to stretch each access by WAIT_CYCLES cycles.
module sram_pair_reader #(
  parameter int unsigned DATA_W = fp_mac_pkg::DATA_W,
  parameter int unsigned DEPTH  = fp_mac_pkg::DEPTH,
  parameter int unsigned ADDR_W = fp_mac_pkg::ADDR_W
`ifdef SRAM_RD_WAIT_EN
  ,
  parameter int unsigned WAIT_CYCLES = 2
`endif
) (
  input logic                clk,
  input logic                rst,
  sram_pair_reader_if.master bus
);

  import fp_mac_pkg::*;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [IDX_W-1:0]  op_idx_q;
  logic              capture;
  logic              last_idx;
  logic              sram_on;

`ifdef SRAM_RD_WAIT_EN
  logic tmr_load;
  logic tmr_dec;
  logic tmr_expire;

  sram_rd_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_rd_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .expire(tmr_expire)
  );
`endif

  assign last_idx = (op_idx_q == IDX_W'(DEPTH - 1));

  // Next-state, address sequencing and capture strobe.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    capture = 1'b0;
`ifdef SRAM_RD_WAIT_EN
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`endif
    if (bus.abort && (state_q != StIdle)) begin
      // Abort beats everything, including a same-cycle acceptance.
      state_d = StIdle;
      addr_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StAccess;
            addr_d  = '0;
          end
        end
        StAccess: begin
`ifdef SRAM_RD_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            capture = 1'b1;
            state_d = StOffer;
          end else begin
            tmr_load = 1'b1;
            state_d  = StWait;
          end
`else
          capture = 1'b1;
          state_d = StOffer;
`endif
        end
        StWait: begin
`ifdef SRAM_RD_WAIT_EN
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            capture = 1'b1;
            state_d = StOffer;
          end
`else
          state_d = StIdle;
          addr_d  = '0;
`endif
        end
        StOffer: begin
          if (bus.pair_ready) begin
            if (last_idx) begin
              state_d = StDone;
              addr_d  = '0;
            end else begin
              state_d = StAccess;
              addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          addr_d  = '0;
        end
        default: begin
          state_d = StIdle;
          addr_d  = '0;
        end
      endcase
    end
  end

  // State, address and captured operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_idx_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (capture) begin
        op_a_q   <= bus.data_a_in;
        op_b_q   <= bus.data_b_in;
        op_idx_q <= IDX_W'(addr_q);
      end
    end
  end

  assign sram_on = (state_q == StAccess) || (state_q == StWait);

  assign bus.cs_a_n     = sram_on ? ASSERT_N : DEASSERT_N;
  assign bus.cs_b_n     = sram_on ? ASSERT_N : DEASSERT_N;
  assign bus.oe_a_n     = sram_on ? ASSERT_N : DEASSERT_N;
  assign bus.oe_b_n     = sram_on ? ASSERT_N : DEASSERT_N;
  assign bus.we_a_n     = DEASSERT_N;
  assign bus.we_b_n     = DEASSERT_N;
  assign bus.addr       = addr_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.op_idx     = op_idx_q;
  assign bus.pair_valid = (state_q == StOffer);
  assign bus.last       = (state_q == StOffer) && last_idx;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_sram_pair_reader.sv
// Scoreboard bench for sram_pair_reader: SRAM models with access latency,
// expected pairs queued by the stimulus, checked by a negedge monitor.
module tb_sram_pair_reader;

`ifdef SRAM_RD_WAIT_EN
  localparam int WaitCyc = 2;
`else
  localparam int WaitCyc = 0;
`endif
  localparam int Lat     = 1 + WaitCyc;
  localparam int PerPair = 2 + WaitCyc;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  idx;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sram_pair_reader_if bus ();

  sram_pair_reader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM models: data valid only after Lat-1 cycles of continuous selection.
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  int cs_age = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) cs_age <= 0;
    else if (bus.cs_a_n) cs_age <= 0;
    else cs_age <= cs_age + 1;
  end

  assign bus.data_a_in = (!bus.cs_a_n && !bus.oe_a_n && (cs_age >= Lat - 1)) ?
                         mem_a[bus.addr[2:0]] : 16'hDEAD;
  assign bus.data_b_in = (!bus.cs_b_n && !bus.oe_b_n && (cs_age >= Lat - 1)) ?
                         mem_b[bus.addr[2:0]] : 16'hBEEF;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  pair_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor state.
  pair_t       e;
  logic        hold_prev = 1'b0;
  logic [34:0] held;
  logic        cs_low_prev = 1'b0;
  logic [3:0]  paddr;
  int          last_acc_cyc = -100;
  int          done_cnt = 0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.pair_valid), 64'(1));
        chk("hold_data", 64'({bus.op_a, bus.op_b, bus.op_idx}), 64'(held));
      end
      if (cs_low_prev && !bus.cs_a_n) chk("addr_stable", 64'(bus.addr), 64'(paddr));
      if (bus.pair_valid)
        chk("cs_oe_in_offer", 64'({bus.cs_a_n, bus.cs_b_n, bus.oe_a_n, bus.oe_b_n}), 64'hF);
      if (bus.pair_valid && bus.pair_ready && !bus.abort) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pair: got idx %0d, required no pair", bus.op_idx);
        end else begin
          e = exp_q.pop_front();
          chk("pair_data", 64'({bus.op_a, bus.op_b, bus.op_idx}), 64'({e.a, e.b, e.idx}));
          chk("last_flag", 64'(bus.last), 64'(e.idx == 3'd7));
        end
        if (bus.last) last_acc_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_acc_cyc + 1));
      end
      hold_prev   = bus.pair_valid && !bus.pair_ready && !bus.abort;
      held        = {bus.op_a, bus.op_b, bus.op_idx};
      cs_low_prev = !bus.cs_a_n;
      paddr       = bus.addr;
    end else begin
      hold_prev   = 1'b0;
      cs_low_prev = 1'b0;
    end
  end

  task automatic push_pairs(input int n);
    pair_t p;
    for (int i = 0; i < n; i++) begin
      p.a   = 16'h3C00 + 16'(i);
      p.b   = 16'h4000 + 16'(i);
      p.idx = 3'(i);
      exp_q.push_back(p);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({bus.cs_a_n, bus.cs_b_n, bus.oe_a_n, bus.oe_b_n,
                             bus.we_a_n, bus.we_b_n}), 64'h3F);
    chk({tag, "_addr"}, 64'(bus.addr), 64'(0));
    chk({tag, "_ops"}, 64'({bus.op_a, bus.op_b, bus.op_idx}), 64'(0));
    chk({tag, "_flags"}, 64'({bus.pair_valid, bus.last, bus.busy, bus.done}), 64'(0));
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready 1-0-0-1; mode 2: ready high plus stray start at idx 2.
  task automatic wait_done(input int mode, output int done_at);
    int n = 0;
    int k = 0;
    bit seen = 0;
    bit pulsed = 0;
    done_at = -1;
    while (!seen && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (mode == 1) begin
        bus.pair_ready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end
      if (mode == 2) begin
        bus.start = 1'b0;
        if (!pulsed && bus.pair_valid && (bus.op_idx == 3'd2)) begin
          bus.start = 1'b1;
          pulsed = 1;
        end
      end
      if (bus.done) begin
        seen = 1;
        done_at = cyc;
      end
    end
    bus.start = 1'b0;
    chk("run_completes", 64'(seen), 64'(1));
    if (mode == 2) chk("stray_start_issued", 64'(pulsed), 64'(1));
  endtask

  // Bounded wait at posedge+1 for a condition selected by sel.
  task automatic wait_for(input int sel, output bit found);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk);
      #1;
      if (sel == 0) found = bus.pair_valid && (bus.op_idx == 3'd3);
      else found = !bus.cs_a_n && (bus.addr == 4'd5);
    end
    chk(sel == 0 ? "reach_offer_idx3" : "reach_access_idx5", 64'(found), 64'(1));
  endtask

  initial begin
    int sc;
    int dat;
    int d0;
    int a0;
    bit found;

    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'h3C00 + 16'(i);
      mem_b[i] = 16'h4000 + 16'(i);
    end
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pair_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;

    // Full run, ready held high.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_pairs(8);
    pulse_start(sc);
    wait_done(0, dat);
    chk("run_len", 64'(dat - sc), 64'(1 + 8 * PerPair));
    chk("run1_pairs", 64'(acc_cnt - a0), 64'(8));
    chk("run1_queue_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    chk("run1_done_count", 64'(done_cnt - d0), 64'(1));
    chk("run1_idle_after", 64'({bus.busy, bus.done}), 64'(0));

    // Backpressure 1-0-0-1.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_pairs(8);
    pulse_start(sc);
    wait_done(1, dat);
    bus.pair_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_pairs", 64'(acc_cnt - a0), 64'(8));
    chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("bp_done_count", 64'(done_cnt - d0), 64'(1));

    // Abort in OFFER of idx 3 with ready high.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_pairs(3);
    pulse_start(sc);
    wait_for(0, found);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_idle", 64'({bus.busy, bus.pair_valid, bus.cs_a_n, bus.cs_b_n}), 64'b0011);
    chk("abort_addr", 64'(bus.addr), 64'(0));
    chk("abort_pairs", 64'(acc_cnt - a0), 64'(3));
    chk("abort_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    a0 = acc_cnt;
    push_pairs(8);
    pulse_start(sc);
    wait_done(0, dat);
    chk("restart_pairs", 64'(acc_cnt - a0), 64'(8));
    chk("restart_queue_empty", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset during ACCESS of idx 5.
    @(posedge clk);
    #1;
    d0 = done_cnt;
    push_pairs(8);
    pulse_start(sc);
    wait_for(1, found);
    #2 rst = 1'b0;
    #1;
    chk_reset("midrun_reset");
    chk("midrun_remaining", 64'(exp_q.size()), 64'(3));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_no_done", 64'(done_cnt - d0), 64'(0));

    // Stray start mid-run is ignored.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_pairs(8);
    pulse_start(sc);
    wait_done(2, dat);
    @(posedge clk);
    #1;
    chk("stray_pairs", 64'(acc_cnt - a0), 64'(8));
    chk("stray_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("stray_done_count", 64'(done_cnt - d0), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("stray_no_rerun", 64'(bus.busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
